jump_sequencer: RTL



---
 rtl/jump_sequencer_pkg.sv | 19 +
 rtl/jump_fault_check.sv | 30 +++
 rtl/jump_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/jump_sequencer_pkg.sv
// Shared definitions for the JAL/JALR sequencer: FSM states, trap causes and
// the only legal JALR funct3 encoding.
package jump_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_CHECK     = 3'd2,
    S_WRITEBACK = 3'd3,
    S_REDIRECT  = 3'd4,
    S_FLUSH     = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [2:0] JALR_FUNCT3            = 3'b000;

endpackage

// File: rtl/jump_fault_check.sv
// Combinational fault classification of a jump: an illegal JALR funct3 takes
// priority over a misaligned target.
module jump_fault_check
  import jump_sequencer_pkg::*;
#(
  parameter bit CHECK_ALIGNMENT = 1'b1
) (
  input  logic        i_is_jalr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_target,
  output logic        o_fault,
  output logic [3:0]  o_cause,
  output logic [31:0] o_tval
);

  always_comb begin
    o_fault = 1'b0;
    o_cause = CAUSE_MISALIGNED_FETCH;
    o_tval  = '0;
    if (i_is_jalr && (i_funct3 != JALR_FUNCT3)) begin
      o_fault = 1'b1;
      o_cause = CAUSE_ILLEGAL_INSTR;
    end else if (CHECK_ALIGNMENT && (i_target[1:0] != 2'b00)) begin
      o_fault = 1'b1;
      o_cause = CAUSE_MISALIGNED_FETCH;
      o_tval  = i_target;
    end
  end

endmodule

// File: rtl/jump_sequencer.sv
// Sequences one JAL/JALR at a time through the external jal/jalr units:
// issue, check, writeback, redirect, flush (or trap).
module jump_sequencer
  import jump_sequencer_pkg::*;
#(
  parameter int FLUSH_CYCLES    = 2,
  parameter bit CHECK_ALIGNMENT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_jalr,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_rs1_value,
  input  logic [31:0] req_immediate,
  input  logic [2:0]  req_funct3,
  output logic [31:0] unit_pc,
  output logic [31:0] unit_rs1_value,
  output logic [31:0] unit_immediate,
  output logic [2:0]  unit_funct3,
  input  logic [31:0] jal_rd_value,
  input  logic [31:0] jal_pc_value,
  input  logic [31:0] jalr_rd_value,
  input  logic [31:0] jalr_pc_value,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_value,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        trap_valid,
  input  logic        trap_ready,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_value,
  output logic        busy
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t            r_state;
  logic              r_is_jalr;
  logic [31:0]       r_pc;
  logic [31:0]       r_rs1;
  logic [31:0]       r_imm;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [31:0]       r_target;
  logic [31:0]       r_link;
  logic [3:0]        r_cause;
  logic [31:0]       r_tval;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [31:0] w_target;
  logic [31:0] w_link;
  logic        w_fault;
  logic [3:0]  w_cause;
  logic [31:0] w_tval;

  // Unit results arrive one cycle after ISSUE, i.e. while in CHECK.
  assign w_target = r_is_jalr ? jalr_pc_value : jal_pc_value;
  assign w_link   = r_is_jalr ? jalr_rd_value : jal_rd_value;

  jump_fault_check #(
    .CHECK_ALIGNMENT(CHECK_ALIGNMENT)
  ) u_fault_check (
    .i_is_jalr(r_is_jalr),
    .i_funct3 (r_funct3),
    .i_target (w_target),
    .o_fault  (w_fault),
    .o_cause  (w_cause),
    .o_tval   (w_tval)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_jalr   <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_imm       <= '0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_target    <= '0;
      r_link      <= '0;
      r_cause     <= '0;
      r_tval      <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_is_jalr <= req_is_jalr;
            r_pc      <= req_pc;
            r_rs1     <= req_rs1_value;
            r_imm     <= req_immediate;
            r_funct3  <= req_funct3;
            r_rd      <= req_rd;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_CHECK;
        S_CHECK: begin
          r_target <= w_target;
          r_link   <= w_link;
          r_cause  <= w_cause;
          r_tval   <= w_tval;
          if (w_fault)           r_state <= S_TRAP;
          else if (r_rd == 5'd0) r_state <= S_REDIRECT;
          else                   r_state <= S_WRITEBACK;
        end
        S_WRITEBACK: if (wb_ready) r_state <= S_REDIRECT;
        S_REDIRECT: begin
          if (redirect_ready) begin
            r_flush_cnt <= CNT_W'(FLUSH_CYCLES);
            r_state     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt - 1'b1;
          if (r_flush_cnt <= CNT_W'(1)) r_state <= S_IDLE;
        end
        S_TRAP: if (trap_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign wb_valid       = (r_state == S_WRITEBACK);
  assign redirect_valid = (r_state == S_REDIRECT);
  assign flush          = (r_state == S_FLUSH);
  assign trap_valid     = (r_state == S_TRAP);

  assign unit_pc        = r_pc;
  assign unit_rs1_value = r_rs1;
  assign unit_immediate = r_imm;
  assign unit_funct3    = r_funct3;
  assign wb_rd          = r_rd;
  assign wb_value       = r_link;
  assign redirect_pc    = r_target;
  assign trap_cause     = r_cause;
  assign trap_pc        = r_pc;
  assign trap_value     = r_tval;

endmodule
